// File: rtl/fifo_pkt_reader.sv
// fifo_pkt_reader: read-side consumer for the dual-clock async FIFO.
// The FIFO carries length-prefixed packets (one LEN header word followed by
// LEN payload words). Headers are popped and interpreted here; payload is
// either forwarded on a registered valid/ready stream with an end-of-packet
// flag, or silently discarded. Delivered and dropped packets are counted
// with saturating counters, and zero-length headers raise a one-cycle pulse.
module fifo_pkt_reader #(
  parameter int DSIZE = 8,
  parameter int CNT_W = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  output logic             rinc,
  input  logic             drop_next,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             zlen_err,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_PAY  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t           state;
  logic [DSIZE-1:0] rem;

  logic hdr_pop;
  logic pay_load;
  logic drop_pop;
  logic rem_is_one;
  logic last_accept;
  logic pkt_sat;
  logic drop_sat;

  assign rem_is_one  = (rem == DSIZE'(1));
  assign last_accept = m_valid & m_ready & m_last;
  assign pkt_sat     = (pkt_cnt == {CNT_W{1'b1}});
  assign drop_sat    = (drop_cnt == {CNT_W{1'b1}});

  // Pop qualifiers per state; a payload word is only taken when the output
  // register is free or being emptied this cycle, so no beat is overwritten.
  always_comb begin
    hdr_pop  = 1'b0;
    pay_load = 1'b0;
    drop_pop = 1'b0;
    case (state)
      S_HDR:   hdr_pop  = ~rempty;
      S_PAY:   pay_load = ~rempty & (~m_valid | m_ready);
      S_DROP:  drop_pop = ~rempty;
      default: hdr_pop  = 1'b0;
    endcase
  end

  assign rinc = hdr_pop | pay_load | drop_pop;
  assign busy = (state != S_HDR) | m_valid;

  // Packet sequencer, stream output register and statistics counters.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state    <= S_HDR;
      rem      <= '0;
      m_data   <= '0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      pkt_cnt  <= '0;
      drop_cnt <= '0;
      zlen_err <= 1'b0;
    end else begin
      zlen_err <= 1'b0;

      if (last_accept && !pkt_sat) begin
        pkt_cnt <= pkt_cnt + CNT_W'(1);
      end

      if (pay_load) begin
        m_data  <= rdata;
        m_valid <= 1'b1;
        m_last  <= rem_is_one;
      end else if (m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end

      case (state)
        S_HDR: begin
          if (hdr_pop) begin
            if (rdata == '0) begin
              zlen_err <= 1'b1;
            end else begin
              rem   <= rdata;
              state <= drop_next ? S_DROP : S_PAY;
            end
          end
        end
        S_PAY: begin
          if (pay_load) begin
            rem <= rem - DSIZE'(1);
            if (rem_is_one) begin
              state <= S_HDR;
            end
          end
        end
        S_DROP: begin
          if (drop_pop) begin
            rem <= rem - DSIZE'(1);
            if (rem_is_one) begin
              if (!drop_sat) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
              end
              state <= S_HDR;
            end
          end
        end
        default: begin
          state <= S_HDR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// tb_fifo_pkt_reader: directed bench for fifo_pkt_reader with a simple
// behavioural FIFO read port and a log of every handshaked stream beat.
module tb_fifo_pkt_reader;

  logic        rclk;
  logic        rrst_n;
  logic [7:0]  rdata;
  logic        rempty;
  logic        rinc;
  logic        drop_next;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;
  logic [15:0] pkt_cnt;
  logic [15:0] drop_cnt;
  logic        zlen_err;
  logic        busy;

  int cmp_n;
  int fail_n;

  logic [7:0] fifo_mem [0:511];
  int         rd_ptr;
  int         wr_ptr;

  logic [7:0] log_data [0:511];
  logic       log_last [0:511];
  int         log_n;
  int         zlen_n;
  int         viol_n;

  fifo_pkt_reader #(.DSIZE(8), .CNT_W(16)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rdata     (rdata),
    .rempty    (rempty),
    .rinc      (rinc),
    .drop_next (drop_next),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .pkt_cnt   (pkt_cnt),
    .drop_cnt  (drop_cnt),
    .zlen_err  (zlen_err),
    .busy      (busy)
  );

  // Free-running read clock.
  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  assign rempty = (rd_ptr == wr_ptr);
  assign rdata  = fifo_mem[rd_ptr[8:0]];

  // FIFO read pointer; popping an empty FIFO is recorded as a violation.
  always @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rd_ptr <= 0;
    end else if (rinc) begin
      if (rempty) viol_n <= viol_n + 1;
      else        rd_ptr <= rd_ptr + 1;
    end
  end

  // Record every accepted beat and every zero-length pulse.
  always @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      log_n  <= 0;
      zlen_n <= 0;
    end else begin
      if (m_valid && m_ready) begin
        log_data[log_n[8:0]] <= m_data;
        log_last[log_n[8:0]] <= m_last;
        log_n <= log_n + 1;
      end
      if (zlen_err) zlen_n <= zlen_n + 1;
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge rclk);
      #1;
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    fifo_mem[wr_ptr[8:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic apply_reset();
    @(negedge rclk);
    rrst_n    = 1'b0;
    m_ready   = 1'b0;
    drop_next = 1'b0;
    wr_ptr    = 0;
    step(2);
    rrst_n = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    apply_reset();
    cmp_n++; if (rinc !== 1'b0) begin fail_n++; $display("[TB] FAIL reset_rinc got=%b want=0", rinc); end
    cmp_n++; if (m_valid !== 1'b0) begin fail_n++; $display("[TB] FAIL reset_m_valid got=%b want=0", m_valid); end
    cmp_n++; if (m_last !== 1'b0) begin fail_n++; $display("[TB] FAIL reset_m_last got=%b want=0", m_last); end
    cmp_n++; if (m_data !== 8'h00) begin fail_n++; $display("[TB] FAIL reset_m_data got=%h want=00", m_data); end
    cmp_n++; if (pkt_cnt !== 16'd0) begin fail_n++; $display("[TB] FAIL reset_pkt_cnt got=%0d want=0", pkt_cnt); end
    cmp_n++; if (drop_cnt !== 16'd0) begin fail_n++; $display("[TB] FAIL reset_drop_cnt got=%0d want=0", drop_cnt); end
    cmp_n++; if (zlen_err !== 1'b0) begin fail_n++; $display("[TB] FAIL reset_zlen_err got=%b want=0", zlen_err); end
    cmp_n++; if (busy !== 1'b0) begin fail_n++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
  endtask

  task automatic test_stream();
    logic [7:0] ev_data [0:4];
    logic       ev_valid [0:4];
    logic       ev_last [0:4];
    ev_valid[0] = 1'b0; ev_data[0] = 8'h00; ev_last[0] = 1'b0;
    ev_valid[1] = 1'b1; ev_data[1] = 8'hA1; ev_last[1] = 1'b0;
    ev_valid[2] = 1'b1; ev_data[2] = 8'hA2; ev_last[2] = 1'b0;
    ev_valid[3] = 1'b1; ev_data[3] = 8'hA3; ev_last[3] = 1'b1;
    ev_valid[4] = 1'b0; ev_data[4] = 8'hA3; ev_last[4] = 1'b0;
    apply_reset();
    m_ready = 1'b1;
    push_word(8'd3); push_word(8'hA1); push_word(8'hA2); push_word(8'hA3);
    #1;
    cmp_n++; if (rinc !== 1'b1) begin fail_n++; $display("[TB] FAIL stream_hdr_rinc got=%b want=1", rinc); end
    for (int i = 0; i < 5; i++) begin
      step(1);
      cmp_n++; if (m_valid !== ev_valid[i]) begin fail_n++; $display("[TB] FAIL stream_valid[%0d] got=%b want=%b", i, m_valid, ev_valid[i]); end
      if (ev_valid[i]) begin
        cmp_n++; if (m_data !== ev_data[i]) begin fail_n++; $display("[TB] FAIL stream_data[%0d] got=%h want=%h", i, m_data, ev_data[i]); end
        cmp_n++; if (m_last !== ev_last[i]) begin fail_n++; $display("[TB] FAIL stream_last[%0d] got=%b want=%b", i, m_last, ev_last[i]); end
      end
    end
    cmp_n++; if (pkt_cnt !== 16'd1) begin fail_n++; $display("[TB] FAIL stream_pkt_cnt got=%0d want=1", pkt_cnt); end
    cmp_n++; if (busy !== 1'b0) begin fail_n++; $display("[TB] FAIL stream_busy_end got=%b want=0", busy); end
  endtask

  task automatic test_backpressure();
    logic [7:0] ex [0:2];
    ex[0] = 8'hA1; ex[1] = 8'hA2; ex[2] = 8'hA3;
    apply_reset();
    m_ready = 1'b1;
    push_word(8'd3); push_word(8'hA1); push_word(8'hA2); push_word(8'hA3);
    step(2);
    m_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      cmp_n++; if (rinc !== 1'b0) begin fail_n++; $display("[TB] FAIL bp_rinc[%0d] got=%b want=0", i, rinc); end
      cmp_n++; if (m_valid !== 1'b1 || m_data !== 8'hA1) begin fail_n++; $display("[TB] FAIL bp_hold[%0d] got=%b/%h want=1/a1", i, m_valid, m_data); end
      step(1);
    end
    m_ready = 1'b1;
    step(6);
    cmp_n++; if (log_n !== 3) begin fail_n++; $display("[TB] FAIL bp_beats got=%0d want=3", log_n); end
    for (int i = 0; i < 3; i++) begin
      cmp_n++; if (log_data[i] !== ex[i] || log_last[i] !== (i == 2)) begin fail_n++; $display("[TB] FAIL bp_beat[%0d] got=%h/%b want=%h/%b", i, log_data[i], log_last[i], ex[i], (i == 2)); end
    end
    cmp_n++; if (pkt_cnt !== 16'd1) begin fail_n++; $display("[TB] FAIL bp_pkt_cnt got=%0d want=1", pkt_cnt); end
  endtask

  task automatic test_drop();
    apply_reset();
    m_ready   = 1'b1;
    drop_next = 1'b1;
    push_word(8'd2); push_word(8'hB1); push_word(8'hB2);
    push_word(8'd1); push_word(8'hC1);
    step(1);
    drop_next = 1'b0;
    step(8);
    cmp_n++; if (drop_cnt !== 16'd1) begin fail_n++; $display("[TB] FAIL drop_cnt got=%0d want=1", drop_cnt); end
    cmp_n++; if (pkt_cnt !== 16'd1) begin fail_n++; $display("[TB] FAIL drop_pkt_cnt got=%0d want=1", pkt_cnt); end
    cmp_n++; if (log_n !== 1) begin fail_n++; $display("[TB] FAIL drop_beats got=%0d want=1", log_n); end
    cmp_n++; if (log_data[0] !== 8'hC1 || log_last[0] !== 1'b1) begin fail_n++; $display("[TB] FAIL drop_c1 got=%h/%b want=c1/1", log_data[0], log_last[0]); end
    cmp_n++; if (rempty !== 1'b1) begin fail_n++; $display("[TB] FAIL drop_fifo_empty got=%b want=1", rempty); end
  endtask

  task automatic test_zero_len();
    apply_reset();
    m_ready = 1'b1;
    push_word(8'd0); push_word(8'd1); push_word(8'hD1);
    step(1);
    cmp_n++; if (zlen_err !== 1'b1) begin fail_n++; $display("[TB] FAIL zlen_pulse got=%b want=1", zlen_err); end
    step(1);
    cmp_n++; if (zlen_err !== 1'b0) begin fail_n++; $display("[TB] FAIL zlen_clear got=%b want=0", zlen_err); end
    step(5);
    cmp_n++; if (zlen_n !== 1) begin fail_n++; $display("[TB] FAIL zlen_count got=%0d want=1", zlen_n); end
    cmp_n++; if (log_n !== 1 || log_data[0] !== 8'hD1 || log_last[0] !== 1'b1) begin fail_n++; $display("[TB] FAIL zlen_d1 got=%0d:%h/%b want=1:d1/1", log_n, log_data[0], log_last[0]); end
    cmp_n++; if (pkt_cnt !== 16'd1) begin fail_n++; $display("[TB] FAIL zlen_pkt_cnt got=%0d want=1", pkt_cnt); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    m_ready = 1'b0;
    push_word(8'd1); push_word(8'h51);
    push_word(8'd2); push_word(8'h61); push_word(8'h62);
    step(3);
    cmp_n++; if (m_valid !== 1'b1 || m_data !== 8'h51 || m_last !== 1'b1) begin fail_n++; $display("[TB] FAIL b2b_x1_held got=%b/%h/%b want=1/51/1", m_valid, m_data, m_last); end
    cmp_n++; if (pkt_cnt !== 16'd0) begin fail_n++; $display("[TB] FAIL b2b_cnt0 got=%0d want=0", pkt_cnt); end
    m_ready = 1'b1;
    step(1);
    cmp_n++; if (m_valid !== 1'b1 || m_data !== 8'h61 || m_last !== 1'b0) begin fail_n++; $display("[TB] FAIL b2b_y1 got=%b/%h/%b want=1/61/0", m_valid, m_data, m_last); end
    cmp_n++; if (pkt_cnt !== 16'd1) begin fail_n++; $display("[TB] FAIL b2b_cnt1 got=%0d want=1", pkt_cnt); end
    step(1);
    cmp_n++; if (m_valid !== 1'b1 || m_data !== 8'h62 || m_last !== 1'b1) begin fail_n++; $display("[TB] FAIL b2b_y2 got=%b/%h/%b want=1/62/1", m_valid, m_data, m_last); end
    step(1);
    cmp_n++; if (pkt_cnt !== 16'd2 || m_valid !== 1'b0) begin fail_n++; $display("[TB] FAIL b2b_end got=%0d/%b want=2/0", pkt_cnt, m_valid); end
    cmp_n++; if (log_n !== 3) begin fail_n++; $display("[TB] FAIL b2b_beats got=%0d want=3", log_n); end
  endtask

  task automatic test_stall_reset();
    apply_reset();
    m_ready = 1'b1;
    push_word(8'd255);
    for (int i = 0; i < 10; i++) push_word(8'(8'h10 + i));
    step(20);
    cmp_n++; if (rinc !== 1'b0) begin fail_n++; $display("[TB] FAIL stall_rinc got=%b want=0", rinc); end
    cmp_n++; if (busy !== 1'b1) begin fail_n++; $display("[TB] FAIL stall_busy got=%b want=1", busy); end
    cmp_n++; if (log_n !== 10) begin fail_n++; $display("[TB] FAIL stall_beats got=%0d want=10", log_n); end
    cmp_n++; if (log_data[9] !== 8'h19 || log_last[9] !== 1'b0) begin fail_n++; $display("[TB] FAIL stall_beat9 got=%h/%b want=19/0", log_data[9], log_last[9]); end
    step(5);
    cmp_n++; if (log_n !== 10 || rinc !== 1'b0) begin fail_n++; $display("[TB] FAIL stall_idle got=%0d/%b want=10/0", log_n, rinc); end
    m_ready = 1'b0;
    push_word(8'h77);
    step(2);
    cmp_n++; if (m_valid !== 1'b1 || m_data !== 8'h77) begin fail_n++; $display("[TB] FAIL stall_pending got=%b/%h want=1/77", m_valid, m_data); end
    rrst_n = 1'b0;
    wr_ptr = 0;
    #1;
    cmp_n++; if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 8'h00) begin fail_n++; $display("[TB] FAIL midrst_stream got=%b/%b/%h want=0/0/00", m_valid, m_last, m_data); end
    cmp_n++; if (busy !== 1'b0 || rinc !== 1'b0 || pkt_cnt !== 16'd0 || drop_cnt !== 16'd0) begin fail_n++; $display("[TB] FAIL midrst_state got=%b/%b/%0d/%0d want=0/0/0/0", busy, rinc, pkt_cnt, drop_cnt); end
    step(2);
    rrst_n  = 1'b1;
    m_ready = 1'b1;
    step(1);
    push_word(8'd1); push_word(8'hE1);
    step(4);
    cmp_n++; if (log_n !== 1 || log_data[0] !== 8'hE1 || log_last[0] !== 1'b1) begin fail_n++; $display("[TB] FAIL postrst_e1 got=%0d:%h/%b want=1:e1/1", log_n, log_data[0], log_last[0]); end
    cmp_n++; if (pkt_cnt !== 16'd1) begin fail_n++; $display("[TB] FAIL postrst_pkt_cnt got=%0d want=1", pkt_cnt); end
  endtask

  initial begin
    cmp_n     = 0;
    fail_n    = 0;
    viol_n    = 0;
    wr_ptr    = 0;
    rrst_n    = 1'b0;
    m_ready   = 1'b0;
    drop_next = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_drop();
    test_zero_len();
    test_back_to_back();
    test_stall_reset();
    cmp_n++; if (viol_n !== 0) begin fail_n++; $display("[TB] FAIL pop_while_empty got=%0d want=0", viol_n); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end

endmodule
